// File: rtl/rgb_window_builder.sv
// Builds a 3x3 RGB neighbourhood window from a raster pixel stream
// using two line buffers and a 3-column shift register.
module rgb_window_builder #(
    parameter int BIT_PER_PIXEL = 8,
    parameter int IMG_WIDTH     = 64,
    parameter int IMG_HEIGHT    = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sof,
    input  logic [BIT_PER_PIXEL-1:0]   in_red,
    input  logic [BIT_PER_PIXEL-1:0]   in_green,
    input  logic [BIT_PER_PIXEL-1:0]   in_blue,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [9*BIT_PER_PIXEL-1:0] out_red,
    output logic [9*BIT_PER_PIXEL-1:0] out_green,
    output logic [9*BIT_PER_PIXEL-1:0] out_blue,
    output logic                       out_eof
);

    localparam int B  = BIT_PER_PIXEL;
    localparam int PW = 3 * B;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0] col_q, col_d, pos_col;
    logic [RW-1:0] row_q, row_d, pos_row;
    logic          out_valid_q, out_valid_d;
    logic          out_eof_q, out_eof_d;
    logic [PW-1:0] win_q [9];
    logic [PW-1:0] win_d [9];
    logic [PW-1:0] line0_mem [IMG_WIDTH];
    logic [PW-1:0] line1_mem [IMG_WIDTH];
    logic [PW-1:0] pix;
    logic          accept;
    logic          produce;
    logic          last_col;
    logic          last_row;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign pix      = {in_red, in_green, in_blue};

    always_comb begin
        pos_col     = in_sof ? '0 : col_q;
        pos_row     = in_sof ? '0 : row_q;
        last_col    = (pos_col == CW'(IMG_WIDTH - 1));
        last_row    = (pos_row == RW'(IMG_HEIGHT - 1));
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        produce     = accept && (pos_row >= RW'(2)) && (pos_col >= CW'(2));
        out_valid_d = out_valid_q;
        out_eof_d   = out_eof_q;

        if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : pos_row + RW'(1);
            end else begin
                col_d = pos_col + CW'(1);
                row_d = pos_row;
            end
            // Oldest column drops out on the left; newest enters at the right.
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = line0_mem[pos_col];
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = line1_mem[pos_col];
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = pix;
        end

        if (produce) begin
            out_valid_d = 1'b1;
            out_eof_d   = last_row && last_col;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_eof_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_eof_q   <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_eof_q   <= out_eof_d;
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= win_d[k];
            end
        end
    end

    // Read-before-write: line1 ages into line0 as the new pixel lands.
    always_ff @(posedge clk) begin
        if (accept) begin
            line0_mem[pos_col] <= line1_mem[pos_col];
            line1_mem[pos_col] <= pix;
        end
    end

    assign out_valid = out_valid_q;
    assign out_eof   = out_eof_q;

    always_comb begin
        out_red   = '0;
        out_green = '0;
        out_blue  = '0;
        for (int k = 0; k < 9; k++) begin
            out_red[k*B +: B]   = win_q[k][2*B +: B];
            out_green[k*B +: B] = win_q[k][B +: B];
            out_blue[k*B +: B]  = win_q[k][0 +: B];
        end
    end

endmodule

// File: tb/tb_rgb_window_builder.sv
// Directed bench for rgb_window_builder on a 4x4 frame.
module tb_rgb_window_builder;

    localparam int B = 8;
    localparam int BASE [4] = '{0, 1, 4, 5};

    typedef struct packed {
        logic [9*B-1:0] r;
        logic [9*B-1:0] g;
        logic [9*B-1:0] b;
        logic           eof;
    } win_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           in_sof = 1'b0;
    logic [B-1:0]   in_red = '0;
    logic [B-1:0]   in_green = '0;
    logic [B-1:0]   in_blue = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [9*B-1:0] out_red;
    logic [9*B-1:0] out_green;
    logic [9*B-1:0] out_blue;
    logic           out_eof;

    int   vec_cnt = 0;
    int   err_cnt = 0;
    win_t got [$];

    rgb_window_builder #(
        .BIT_PER_PIXEL(B),
        .IMG_WIDTH(4),
        .IMG_HEIGHT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_sof(in_sof),
        .in_red(in_red),
        .in_green(in_green),
        .in_blue(in_blue),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_red(out_red),
        .out_green(out_green),
        .out_blue(out_blue),
        .out_eof(out_eof)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && out_valid && out_ready) begin
            got.push_back('{r: out_red, g: out_green, b: out_blue, eof: out_eof});
        end
    end

    function automatic logic [9*B-1:0] exp_win(input int base, input int off);
        logic [9*B-1:0] v;
        for (int k = 0; k < 9; k++) begin
            v[k*B +: B] = B'(base + (k / 3) * 4 + (k % 3) + off);
        end
        return v;
    endfunction

    function automatic bit has_win(input int i);
        return (i / 4 >= 2) && (i % 4 >= 2);
    endfunction

    task automatic do_reset(input int cycles);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        reset    = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send(input int idx, input bit sof);
        int n = 0;
        in_valid = 1'b1;
        in_sof   = sof;
        in_red   = B'(idx);
        in_green = B'(idx + 64);
        in_blue  = B'(idx + 128);
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL send_timeout idx=%0d in_ready=%b required 1", idx, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic test_reset;
        do_reset(2);
        vec_cnt++;
        if (out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_valid got=%b required 0", out_valid);
        end
        vec_cnt++;
        if (out_eof !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_eof got=%b required 0", out_eof);
        end
        vec_cnt++;
        if ({out_red, out_green, out_blue} !== '0) begin
            err_cnt++;
            $display("FAIL reset_data got=%h required 0", {out_red, out_green, out_blue});
        end
        vec_cnt++;
        if (in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_in_ready got=%b required 1", in_ready);
        end
    endtask

    task automatic test_stream;
        do_reset(2);
        got.delete();
        for (int i = 0; i < 16; i++) begin
            send(i, i == 0);
            vec_cnt++;
            if (out_valid !== has_win(i)) begin
                err_cnt++;
                $display("FAIL stream_valid i=%0d got=%b required %b", i, out_valid, has_win(i));
            end
        end
        @(posedge clk);
        #1;
        vec_cnt++;
        if (got.size() != 4) begin
            err_cnt++;
            $display("FAIL stream_count got=%0d required 4", got.size());
        end
        for (int w = 0; w < 4 && w < got.size(); w++) begin
            vec_cnt++;
            if (got[w].r !== exp_win(BASE[w], 0) || got[w].g !== exp_win(BASE[w], 64) ||
                got[w].b !== exp_win(BASE[w], 128) || got[w].eof !== (w == 3)) begin
                err_cnt++;
                $display("FAIL stream_win%0d got r=%h eof=%b required r=%h eof=%b",
                         w, got[w].r, got[w].eof, exp_win(BASE[w], 0), w == 3);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [9*B-1:0] held;
        do_reset(2);
        got.delete();
        for (int i = 0; i < 11; i++) send(i, i == 0);
        out_ready = 1'b0;
        held      = out_red;
        in_valid  = 1'b1;
        in_red    = B'(11);
        in_green  = B'(11 + 64);
        in_blue   = B'(11 + 128);
        repeat (3) begin
            @(posedge clk);
            #1;
            vec_cnt++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_red !== held || out_eof !== 1'b0) begin
                err_cnt++;
                $display("FAIL stall_hold in_ready=%b valid=%b r=%h required 0 1 %h",
                         in_ready, out_valid, out_red, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        vec_cnt++;
        if (out_valid !== 1'b1 || out_red !== exp_win(1, 0)) begin
            err_cnt++;
            $display("FAIL bp_second valid=%b r=%h required 1 %h", out_valid, out_red, exp_win(1, 0));
        end
        for (int i = 12; i < 16; i++) send(i, 1'b0);
        @(posedge clk);
        #1;
        vec_cnt++;
        if (got.size() != 4) begin
            err_cnt++;
            $display("FAIL bp_count got=%0d required 4", got.size());
        end
        for (int w = 0; w < 4 && w < got.size(); w++) begin
            vec_cnt++;
            if (got[w].r !== exp_win(BASE[w], 0) || got[w].b !== exp_win(BASE[w], 128) ||
                got[w].eof !== (w == 3)) begin
                err_cnt++;
                $display("FAIL bp_win%0d got r=%h required r=%h", w, got[w].r, exp_win(BASE[w], 0));
            end
        end
    endtask

    task automatic test_row_boundary;
        do_reset(2);
        for (int i = 0; i < 12; i++) send(i, i == 0);
        send(12, 1'b0);
        vec_cnt++;
        if (out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL row_i12 valid=%b required 0", out_valid);
        end
        send(13, 1'b0);
        vec_cnt++;
        if (out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL row_i13 valid=%b required 0", out_valid);
        end
        send(14, 1'b0);
        vec_cnt++;
        if (out_valid !== 1'b1 || out_red !== exp_win(4, 0) || out_green !== exp_win(4, 64)) begin
            err_cnt++;
            $display("FAIL row_i14 valid=%b r=%h required 1 %h", out_valid, out_red, exp_win(4, 0));
        end
        send(15, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_bubbles;
        do_reset(2);
        got.delete();
        for (int i = 0; i < 16; i++) begin
            send(i, i == 0);
            @(posedge clk);
            #1;
        end
        vec_cnt++;
        if (got.size() != 4) begin
            err_cnt++;
            $display("FAIL bubble_count got=%0d required 4", got.size());
        end
        for (int w = 0; w < 4 && w < got.size(); w++) begin
            vec_cnt++;
            if (got[w].r !== exp_win(BASE[w], 0) || got[w].g !== exp_win(BASE[w], 64) ||
                got[w].b !== exp_win(BASE[w], 128) || got[w].eof !== (w == 3)) begin
                err_cnt++;
                $display("FAIL bubble_win%0d got r=%h required r=%h", w, got[w].r, exp_win(BASE[w], 0));
            end
        end
    endtask

    task automatic test_reset_mid;
        do_reset(2);
        for (int i = 0; i < 10; i++) send(i, i == 0);
        do_reset(1);
        vec_cnt++;
        if (out_valid !== 1'b0 || out_eof !== 1'b0 || {out_red, out_green, out_blue} !== '0) begin
            err_cnt++;
            $display("FAIL midreset_outputs valid=%b eof=%b r=%h required 0 0 0",
                     out_valid, out_eof, out_red);
        end
        got.delete();
        for (int i = 0; i < 16; i++) begin
            send(i, 1'b0);
            vec_cnt++;
            if (out_valid !== has_win(i)) begin
                err_cnt++;
                $display("FAIL midreset_valid i=%0d got=%b required %b", i, out_valid, has_win(i));
            end
        end
        @(posedge clk);
        #1;
        for (int w = 0; w < 4 && w < got.size(); w++) begin
            vec_cnt++;
            if (got[w].r !== exp_win(BASE[w], 0) || got[w].eof !== (w == 3)) begin
                err_cnt++;
                $display("FAIL midreset_win%0d got r=%h required r=%h", w, got[w].r, exp_win(BASE[w], 0));
            end
        end
    endtask

    task automatic test_resync;
        do_reset(2);
        for (int i = 0; i < 6; i++) send(i + 200, 1'b0);
        got.delete();
        for (int i = 0; i < 16; i++) send(i, i == 0);
        @(posedge clk);
        #1;
        vec_cnt++;
        if (got.size() != 4) begin
            err_cnt++;
            $display("FAIL resync_count got=%0d required 4", got.size());
        end
        for (int w = 0; w < 4 && w < got.size(); w++) begin
            vec_cnt++;
            if (got[w].r !== exp_win(BASE[w], 0) || got[w].g !== exp_win(BASE[w], 64) ||
                got[w].b !== exp_win(BASE[w], 128) || got[w].eof !== (w == 3)) begin
                err_cnt++;
                $display("FAIL resync_win%0d got r=%h required r=%h", w, got[w].r, exp_win(BASE[w], 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_row_boundary();
        test_bubbles();
        test_reset_mid();
        test_resync();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/rgb_window_builder.md
Name: rgb_window_builder

Overview:
- Upstream stage of the grayscale converter. Accepts a raster-order RGB pixel stream (one pixel per handshake) and buffers two image lines internally.
- Emits a 3x3 RGB neighbourhood window for every pixel position with a full 3x3 neighbourhood. Each window carries 9 pixels x 3 channels, laid out to feed the converter's pixel_0..pixel_8 red/green/blue inputs directly.
- Ready/valid handshake on both sides; the output side supports backpressure.

Parameters:
- BIT_PER_PIXEL, 8, width of one colour channel.
- IMG_WIDTH, 64, pixels per line (>=3).
- IMG_HEIGHT, 64, lines per frame (>=3).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept a pixel this cycle
- in_sof  in  1  qualifies the accepted pixel as frame position (0,0)
- in_red  in  BIT_PER_PIXEL  red channel
- in_green  in  BIT_PER_PIXEL  green channel
- in_blue  in  BIT_PER_PIXEL  blue channel
- out_valid  out  1  window valid
- out_ready  in  1  downstream accepts window
- out_red  out  9*BIT_PER_PIXEL  red of pixel k at bits [k*BIT_PER_PIXEL +: BIT_PER_PIXEL]
- out_green  out  9*BIT_PER_PIXEL  green, same packing
- out_blue  out  9*BIT_PER_PIXEL  blue, same packing
- out_eof  out  1  window is the last one of the frame

Behaviour:
- Reset is decided: reset reset, synchronous, active-high; clock clk.
- Reset values: out_valid=0, out_eof=0, out_red/green/blue=0, column counter=0, row counter=0, window registers=0.
  - Line buffer RAMs are not cleared.
  - in_ready=1 in the first cycle after reset.
- Accept: a pixel is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready (combinational).
- Position counters (col 0..IMG_WIDTH-1, row 0..IMG_HEIGHT-1) advance once per accepted pixel.
  - col wraps to 0 and row increments at IMG_WIDTH-1.
  - At the last pixel (row IMG_HEIGHT-1, col IMG_WIDTH-1) both wrap to 0.
- in_sof=1 on an accepted pixel forces that pixel's position to (0,0), regardless of the counters. The counters then continue from (0,1).
- Line buffers: two RAMs, IMG_WIDTH x 3*BIT_PER_PIXEL, addressed by col.
  - Read-before-write: on each accept, line1[col] moves to line0[col], and the new pixel is written to line1[col].
  - A 3x3 shift register takes column {line0[col], line1[col], new pixel}. Columns shift left, oldest column discarded.
- Window layout: pixel k = row k/3, column k%3.
  - k=0 is top-left (row r-2, col c-2).
  - k=8 is the just-accepted pixel (row r, col c).
- Window emission: when the accepted pixel has row>=2 and col>=2, out_valid is set at the next rising edge with the updated window. Latency is 1 cycle from accept.
  - Pixels with row<2 or col<2 produce no window. No window ever spans a line wrap.
  - Output count per frame is (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- out_eof=1 with the window whose accepted pixel is (IMG_HEIGHT-1, IMG_WIDTH-1). Otherwise out_eof=0.
- Output hold: while out_valid && !out_ready, out_red/green/blue/eof are held stable and in_ready=0.
  - out_valid clears on out_valid && out_ready, unless a new window is produced in the same cycle.
  - Simultaneous handshake: output consumed and new pixel accepted in the same cycle. If the new pixel yields a window, out_valid stays 1 with new data, giving full throughput of one pixel per cycle.
- Bubbles (in_valid=0) do not alter counters, buffers or the window.
- Reset mid-frame: counters return to (0,0) and any pending window is dropped. Stale line-buffer data is overwritten before use, because rows 0 and 1 are rewritten before any window is emitted.
- Arithmetic: counters sized $clog2 of IMG_WIDTH / IMG_HEIGHT. Data passes bit-exact; no arithmetic on pixel data.

Test Plan:
- Bench configuration: IMG_WIDTH=4, IMG_HEIGHT=4, out_ready=1. Stream indices i=0..15, in_sof on i=0, red=i, green=i+64, blue=i+128.
  - Exactly 4 windows.
  - First window one cycle after accepting i=10: red=0,1,2,4,5,6,8,9,10.
  - Last window after i=15: red=5,6,7,9,10,11,13,14,15, green=red+64, out_eof=1 only on this window.
- Backpressure: same stream, out_ready=0 for 3 cycles after the first window.
  - Window held stable and in_ready=0 during the stall; no pixel lost.
  - Second window red=1,2,3,5,6,7,9,10,11.
- Row boundary: accepting i=12 and i=13 produces no window (out_valid stays 0). i=14 yields red=4,5,6,8,9,10,12,13,14.
- Bubbles: in_valid toggled every other cycle → identical 4-window sequence and values as the first scenario.
- Reset mid-frame: reset one cycle after i=9 → all outputs 0. A restarted frame i=0..15 produces the first window exactly after its 11th accept, with correct values.
- Resync: in_sof asserted on stream pixel 6 with data index 0, followed by a full 16-pixel frame → windows match the first scenario exactly.
